param_cache_ctrl: RTL and testbench

- Parametrised N-way set-associative, multi-word-block, write-back / write-allocate data cache, placed between the pipeline MEM stage and the block-wide data memory.
- Stalls the pipeline via busywait on a miss, runs a writeback/allocate FSM against memory, and replaces victims by true LRU with per-way age counters.
- Keeps saturating hit and miss counters for performance measurement.

---
 rtl/param_cache_ctrl.sv | 178 +++++++++++++++++
 tb/tb_param_cache_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/param_cache_ctrl.sv
// N-way write-back/write-allocate data cache with true-LRU ages; hits complete in the request cycle.
// A miss holds busywait for the writeback and fill handshakes plus one update cycle; mem_busywait stalls the FSM.
module param_cache_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int NUM_SETS        = 8,
   parameter int WAYS            = 2,
   parameter int ADDR_WIDTH      = 32,
   localparam int BO  = $clog2(DATA_WIDTH/8),
   localparam int WO  = $clog2(WORDS_PER_BLOCK),
   localparam int BW  = DATA_WIDTH*WORDS_PER_BLOCK,
   localparam int MW  = ADDR_WIDTH-BO-WO
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  busywait,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [MW-1:0]         mem_address,
   output logic [BW-1:0]         mem_writedata,
   input  logic [BW-1:0]         mem_readdata,
   input  logic                  mem_busywait,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);
   localparam int IW  = $clog2(NUM_SETS);
   localparam int TW  = ADDR_WIDTH-BO-WO-IW;
   localparam int AW  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WOW = (WO > 0) ? WO : 1;
   localparam logic [AW-1:0] AGE_MAX = AW'(WAYS-1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] ALLOCATE  = 2'd2;
   localparam logic [1:0] UPDATE    = 2'd3;

   logic [NUM_SETS-1:0][WAYS-1:0]          valid;
   logic [NUM_SETS-1:0][WAYS-1:0]          dirty;
   logic [NUM_SETS-1:0][WAYS-1:0][AW-1:0]  age;
   logic [TW-1:0]                          tags [NUM_SETS][WAYS];
   logic [BW-1:0]                          data [NUM_SETS][WAYS];

   logic [1:0]      state;
   logic            first;
   logic [AW-1:0]   victim;
   logic [BW-1:0]   fill;

   logic [IW-1:0]   idx;
   logic [TW-1:0]   tag;
   logic [WOW-1:0]  woff;
   logic            req, match, hit, found, lru_en;
   logic [AW-1:0]   hit_way, vict, lru_way;
   logic [BW-1:0]   hit_blk;

   assign idx = address[BO+WO +: IW];
   assign tag = address[ADDR_WIDTH-1 -: TW];

   if (WO > 0) begin : g_woff
      assign woff = address[BO +: WO];
   end else begin : g_no_woff
      assign woff = '0;
   end

   if (BO > 0) begin : g_bo
      logic unused_byte_bits;
      assign unused_byte_bits = ^address[BO-1:0];
   end

   function automatic logic [WAYS-1:0][AW-1:0] way_ages();
      logic [WAYS-1:0][AW-1:0] r;
      for (int w = 0; w < WAYS; w++) r[w] = AW'(w);
      return r;
   endfunction

   assign req = read | write;

   always_comb begin
      match   = 1'b0;
      hit_way = '0;
      found   = 1'b0;
      vict    = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!match && valid[idx][w] && tags[idx][w] == tag) begin
            match   = 1'b1;
            hit_way = AW'(w);
         end
      end
      // Prefer an empty way; otherwise evict the oldest.
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid[idx][w]) begin
            found = 1'b1;
            vict  = AW'(w);
         end
      end
      if (!found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age[idx][w] == AGE_MAX) vict = AW'(w);
         end
      end
   end

   assign hit     = (state == IDLE) && req && match;
   assign hit_blk = data[idx][hit_way];
   assign lru_en  = hit || (state == UPDATE);
   assign lru_way = (state == UPDATE) ? victim : hit_way;

   assign readdata      = hit ? hit_blk[woff*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign busywait      = (state != IDLE) || (req && !match);
   assign mem_write     = (state == WRITEBACK);
   assign mem_read      = (state == ALLOCATE);
   assign mem_address   = (state == WRITEBACK) ? {tags[idx][victim], idx} : {tag, idx};
   assign mem_writedata = data[idx][victim];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         first      <= 1'b0;
         victim     <= '0;
         valid      <= '0;
         dirty      <= '0;
         age        <= {NUM_SETS{way_ages()}};
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hit) begin
                  if (write) begin
                     data[idx][hit_way][woff*DATA_WIDTH +: DATA_WIDTH] <= writedata;
                     dirty[idx][hit_way] <= 1'b1;
                  end
                  if (hit_count != '1) hit_count <= hit_count + 32'd1;
               end else if (req) begin
                  victim <= vict;
                  first  <= 1'b1;
                  if (miss_count != '1) miss_count <= miss_count + 32'd1;
                  state  <= (valid[idx][vict] && dirty[idx][vict]) ? WRITEBACK : ALLOCATE;
               end
            end
            // The memory raises mem_busywait only after seeing the strobe, so the first edge is ignored.
            WRITEBACK: begin
               first <= 1'b0;
               if (!first && !mem_busywait) begin
                  state <= ALLOCATE;
                  first <= 1'b1;
               end
            end
            ALLOCATE: begin
               first <= 1'b0;
               if (!first && !mem_busywait) begin
                  fill  <= mem_readdata;
                  state <= UPDATE;
               end
            end
            default: begin
               data[idx][victim]  <= fill;
               tags[idx][victim]  <= tag;
               valid[idx][victim] <= 1'b1;
               dirty[idx][victim] <= 1'b0;
               state              <= IDLE;
            end
         endcase
         if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
               if (AW'(w) == lru_way)
                  age[idx][w] <= '0;
               else if (age[idx][w] < age[idx][lru_way])
                  age[idx][w] <= age[idx][w] + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_param_cache_ctrl.sv
// Directed bench for param_cache_ctrl: read-data and memory-request scoreboards against a fixed-latency memory.
module tb_param_cache_ctrl;
   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          reset, read, write;
   logic [31:0]   address, writedata;
   logic [31:0]   readdata;
   logic          busywait, mem_read, mem_write, mem_busywait;
   logic [27:0]   mem_address;
   logic [127:0]  mem_writedata, mem_readdata;
   logic [31:0]   hit_count, miss_count;

   param_cache_ctrl dut (
      .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
      .writedata(writedata), .readdata(readdata), .busywait(busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {bit wr; logic [27:0] addr; bit chk; logic [31:0] w2;} mexp_t;

   int            checks = 0;
   int            errors = 0;
   mexp_t         mq[$];
   logic [31:0]   rq[$];
   logic [127:0]  mem_store [int];
   mexp_t         cur;
   int            cyc = 0;
   bit            pw = 1'b0;
   int            n;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] blk(int b);
      logic [127:0] r;
      if (mem_store.exists(b)) return mem_store[b];
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = 32'hAAAA0000 + 32'((b-4)*16 + w);
      return r;
   endfunction

   // Memory: busy from the second strobe cycle for LAT cycles, then one completing cycle.
   initial begin
      mem_busywait = 1'b0;
      mem_readdata = '0;
      forever begin
         @(posedge clk); #1;
         if (!(mem_read || mem_write)) begin
            cyc = 0;
            mem_busywait = 1'b0;
         end else begin
            if (cyc == 0 || pw != mem_write) cyc = 1; else cyc++;
            pw = mem_write;
            if (cyc == 1) begin
               chk("mem_exclusive", 32'({mem_read, mem_write} == 2'b11), 32'd0);
               chk("mem_req_expected", 32'(mq.size() > 0), 32'd1);
               if (mq.size() > 0) begin
                  cur = mq.pop_front();
                  chk("mem_kind", 32'(mem_write), 32'(cur.wr));
                  chk("mem_addr", 32'(mem_address), 32'(cur.addr));
               end
            end
            mem_busywait = (cyc >= 2 && cyc <= LAT+1);
            if (mem_read) mem_readdata = blk(int'(mem_address));
            if (mem_write && cyc == LAT+2) begin
               mem_store[int'(mem_address)] = mem_writedata;
               if (cur.chk) chk("wb_word2", mem_writedata[95:64], cur.w2);
            end
         end
      end
   end

   task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] wd,
                         bit exp_miss, bit chk_rd, logic [31:0] exp_rd, string tag);
      int k = 0;
      if (chk_rd) rq.push_back(exp_rd);
      read = rd; write = wr; address = a; writedata = wd;
      @(negedge clk);
      chk({tag, "_busy_first"}, 32'(busywait), 32'(exp_miss));
      if (!exp_miss) chk({tag, "_no_strobe"}, 32'({mem_read, mem_write}), 32'd0);
      while (busywait && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"}, 32'(busywait), 32'd0);
      if (chk_rd) chk({tag, "_rdata"}, readdata, rq.pop_front());
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busywait", 32'(busywait), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);
      chk("rst_readdata", readdata, 32'd0);

      mq.push_back('{wr:1'b0, addr:28'h4, chk:1'b0, w2:32'h0});
      access(1, 0, 32'h40, 0, 1, 1, 32'hAAAA0000, "rd40_miss");
      chk("misses_1", miss_count, 32'd1);
      chk("hits_1", hit_count, 32'd1);

      access(1, 0, 32'h44, 0, 0, 1, 32'hAAAA0001, "rd44_hit");
      chk("hits_2", hit_count, 32'd2);

      access(0, 1, 32'h48, 32'h12345678, 0, 0, 0, "wr48_hit");
      access(1, 0, 32'h48, 0, 0, 1, 32'h12345678, "rd48_hit");
      chk("hits_4", hit_count, 32'd4);

      mq.push_back('{wr:1'b0, addr:28'hC, chk:1'b0, w2:32'h0});
      access(1, 0, 32'hC0, 0, 1, 1, 32'hAAAA0080, "rdC0_fill_way1");
      mq.push_back('{wr:1'b1, addr:28'h4, chk:1'b1, w2:32'h12345678});
      mq.push_back('{wr:1'b0, addr:28'h14, chk:1'b0, w2:32'h0});
      access(1, 0, 32'h140, 0, 1, 1, 32'hAAAA0100, "rd140_evict");
      access(1, 0, 32'hC0, 0, 0, 1, 32'hAAAA0080, "rdC0_rehit");
      chk("misses_3", miss_count, 32'd3);
      chk("hits_7", hit_count, 32'd7);

      // The written-back line returns from memory with the stored word.
      mq.push_back('{wr:1'b0, addr:28'h4, chk:1'b0, w2:32'h0});
      access(1, 0, 32'h48, 0, 1, 1, 32'h12345678, "rd48_refill");
      chk("misses_4", miss_count, 32'd4);
      chk("hits_8", hit_count, 32'd8);

      access(1, 1, 32'h44, 32'h5, 0, 0, 0, "rdwr44");
      access(1, 0, 32'h44, 0, 0, 1, 32'h5, "rd44_after_rdwr");
      chk("hits_10", hit_count, 32'd10);

      mq.push_back('{wr:1'b0, addr:28'h20, chk:1'b0, w2:32'h0});
      read = 1'b1; address = 32'h200;
      n = 0;
      @(negedge clk);
      while (!mem_read && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("alloc_reached", 32'(mem_read), 32'd1);
      @(posedge clk); #1;
      reset = 1'b1; read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_mem_read", 32'(mem_read), 32'd0);
      chk("abort_busywait", 32'(busywait), 32'd0);
      chk("abort_misses", miss_count, 32'd0);

      mq.push_back('{wr:1'b0, addr:28'h20, chk:1'b0, w2:32'h0});
      access(1, 0, 32'h200, 0, 1, 1, 32'hAAAA01C0, "rd200_after_abort");
      chk("misses_after_abort", miss_count, 32'd1);
      chk("hits_after_abort", hit_count, 32'd1);

      repeat (2) @(posedge clk);
      chk("mem_q_drained", 32'(mq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
